// File: rtl/ucsbece154_mem_pkg.sv
// Shared memory-arbiter types: FSM state encoding, default burst size.
// Imported by the arbiter and by the system top that instantiates it.
package ucsbece154_mem_pkg;

  localparam int MEM_BLOCK_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE
  } memState_t;

endpackage

// File: rtl/ucsbece154_mem_arbiter.sv
// Round-robin icache/dcache arbiter in front of one SDRAM port.
// i_*: icache burst read; d_*: dcache burst read / single write;
// ReadRequest/WriteRequest/Address/WriteData/DataIn/DataReady/
// WriteDone: SDRAM side. Async active-low reset.
module ucsbece154_mem_arbiter
  import ucsbece154_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = MEM_BLOCK_WORDS,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ReadRequest,
  input  logic [WIDTH-1:0] i_ReadAddress,
  output logic [WIDTH-1:0] i_DataIn,
  output logic             i_DataReady,
  input  logic             d_ReadRequest,
  input  logic             d_WriteRequest,
  input  logic [WIDTH-1:0] d_Address,
  input  logic [WIDTH-1:0] d_WriteData,
  output logic [WIDTH-1:0] d_DataIn,
  output logic             d_DataReady,
  output logic             d_WriteDone,
  output logic             ReadRequest,
  output logic             WriteRequest,
  output logic [WIDTH-1:0] Address,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             DataReady,
  input  logic             WriteDone
);

  localparam int CW = $clog2(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  memState_t        state;
  memState_t        stateNext;
  logic [CW-1:0]    beatCnt;
  logic             lastGrant;
  logic [WIDTH-1:0] addrReg;
  logic [WIDTH-1:0] wdataReg;

  logic dReq;
  logic pickD;
  logic pickI;
  logic grant;
  logic inRead;
  logic lastBeat;

  // lastGrant: 1 = dcache was served last, so icache wins a tie
  assign dReq     = d_ReadRequest | d_WriteRequest;
  assign pickD    = dReq & (~i_ReadRequest | ~lastGrant);
  assign pickI    = i_ReadRequest & ~pickD;
  assign grant    = (state == IDLE) & (pickD | pickI);
  assign inRead   = (state == I_READ) | (state == D_READ);
  assign lastBeat = DataReady & (beatCnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (pickD) begin
          stateNext = d_WriteRequest ? D_WRITE : D_READ;
        end else if (pickI) begin
          stateNext = I_READ;
        end
      end
      I_READ, D_READ: begin
        if (lastBeat) stateNext = IDLE;
      end
      D_WRITE: begin
        if (WriteDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beatCnt   <= '0;
      lastGrant <= 1'b1;
      addrReg   <= '0;
      wdataReg  <= '0;
    end else if (grant) begin
      beatCnt   <= '0;
      lastGrant <= pickD;
      addrReg   <= pickD ? d_Address : i_ReadAddress;
      if (pickD & d_WriteRequest) wdataReg <= d_WriteData;
    end else if (inRead & DataReady) begin
      beatCnt <= beatCnt + 1'b1;
    end
  end

  always_comb begin
    ReadRequest  = inRead;
    WriteRequest = (state == D_WRITE);
    Address      = addrReg;
    WriteData    = wdataReg;
    i_DataReady  = DataReady & (state == I_READ);
    d_DataReady  = DataReady & (state == D_READ);
    d_WriteDone  = WriteDone & (state == D_WRITE);
    // data forwarding is combinational; hold it at 0 during reset
    i_DataIn     = reset ? DataIn : '0;
    d_DataIn     = reset ? DataIn : '0;
  end

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Directed self-checking bench for ucsbece154_mem_arbiter.
// Inputs change on the falling edge; outputs are checked #1 later.
module tb_ucsbece154_mem_arbiter;

  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_ReadRequest;
  logic [31:0] i_ReadAddress;
  logic [31:0] i_DataIn;
  logic        i_DataReady;
  logic        d_ReadRequest;
  logic        d_WriteRequest;
  logic [31:0] d_Address;
  logic [31:0] d_WriteData;
  logic [31:0] d_DataIn;
  logic        d_DataReady;
  logic        d_WriteDone;
  logic        ReadRequest;
  logic        WriteRequest;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] DataIn;
  logic        DataReady;
  logic        WriteDone;

  int nAsserts = 0;
  int nFails   = 0;

  ucsbece154_mem_arbiter #(.BLOCK_WORDS(BW), .WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .i_ReadRequest(i_ReadRequest),
    .i_ReadAddress(i_ReadAddress),
    .i_DataIn(i_DataIn),
    .i_DataReady(i_DataReady),
    .d_ReadRequest(d_ReadRequest),
    .d_WriteRequest(d_WriteRequest),
    .d_Address(d_Address),
    .d_WriteData(d_WriteData),
    .d_DataIn(d_DataIn),
    .d_DataReady(d_DataReady),
    .d_WriteDone(d_WriteDone),
    .ReadRequest(ReadRequest),
    .WriteRequest(WriteRequest),
    .Address(Address),
    .WriteData(WriteData),
    .DataIn(DataIn),
    .DataReady(DataReady),
    .WriteDone(WriteDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nAsserts++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  // One full read burst; dropAt >= 0 clears both request lines
  // right after that beat (grant must hold regardless).
  task automatic burst(input string tag,
                       input logic toI,
                       input logic [31:0] addr,
                       input logic [31:0] base,
                       input int dropAt);
    for (int k = 0; k < BW; k++) begin
      @(negedge clk);
      check({tag, "_rreq"}, 32'(ReadRequest), 32'd1);
      check({tag, "_wreq"}, 32'(WriteRequest), 32'd0);
      check({tag, "_addr"}, Address, addr);
      DataReady = 1'b1;
      DataIn    = base + 32'(k);
      #1;
      check({tag, "_irdy"}, 32'(i_DataReady), 32'(toI));
      check({tag, "_drdy"}, 32'(d_DataReady), 32'(!toI));
      if (toI) check({tag, "_idata"}, i_DataIn, base + 32'(k));
      else     check({tag, "_ddata"}, d_DataIn, base + 32'(k));
      if (k == dropAt) begin
        i_ReadRequest = 1'b0;
        d_ReadRequest = 1'b0;
      end
    end
    @(negedge clk);
    DataReady = 1'b0;
    DataIn    = '0;
    #1;
    check({tag, "_endRreq"}, 32'(ReadRequest), 32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    i_ReadRequest  = 1'b0;
    i_ReadAddress  = '0;
    d_ReadRequest  = 1'b0;
    d_WriteRequest = 1'b0;
    d_Address      = '0;
    d_WriteData    = '0;
    DataIn         = 32'h5555_5555;
    DataReady      = 1'b1;
    WriteDone      = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_rreq", 32'(ReadRequest), 32'd0);
    check("rst_wreq", 32'(WriteRequest), 32'd0);
    check("rst_addr", Address, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_idata", i_DataIn, 32'd0);
    check("rst_ddata", d_DataIn, 32'd0);
    check("rst_irdy", 32'(i_DataReady), 32'd0);
    check("rst_drdy", 32'(d_DataReady), 32'd0);
    check("rst_wdone", 32'(d_WriteDone), 32'd0);

    @(negedge clk);
    reset     = 1'b1;
    DataIn    = '0;
    DataReady = 1'b0;
    WriteDone = 1'b0;

    // icache-only burst at 0x100
    i_ReadRequest = 1'b1;
    i_ReadAddress = 32'h100;
    burst("i033", 1'b1, 32'h100, 32'hA0, BW - 1);

    // tie after reset: icache, then dcache, then icache again
    reset = 1'b0;
    @(negedge clk);
    reset         = 1'b1;
    i_ReadRequest = 1'b1;
    i_ReadAddress = 32'h300;
    d_ReadRequest = 1'b1;
    d_Address     = 32'h400;
    burst("tieI", 1'b1, 32'h300, 32'hB0, -1);
    burst("tieD", 1'b0, 32'h400, 32'hC0, -1);
    burst("tieI2", 1'b1, 32'h300, 32'hB4, 0);

    // request dropped after the first beat
    i_ReadRequest = 1'b1;
    i_ReadAddress = 32'h180;
    burst("i036", 1'b1, 32'h180, 32'hE0, 0);

    // stray acks while idle
    @(negedge clk);
    DataReady = 1'b1;
    DataIn    = 32'h77;
    WriteDone = 1'b1;
    #1;
    check("stray_irdy", 32'(i_DataReady), 32'd0);
    check("stray_drdy", 32'(d_DataReady), 32'd0);
    check("stray_wdone", 32'(d_WriteDone), 32'd0);
    @(negedge clk);
    DataReady = 1'b0;
    WriteDone = 1'b0;
    #1;
    check("stray_rreq", 32'(ReadRequest), 32'd0);
    check("stray_wreq", 32'(WriteRequest), 32'd0);

    // dcache write (with a read also pending) to 0x200
    d_WriteRequest = 1'b1;
    d_ReadRequest  = 1'b1;
    d_Address      = 32'h200;
    d_WriteData    = 32'hDEAD_BEEF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        d_WriteRequest = 1'b0;
        d_ReadRequest  = 1'b0;
        d_Address      = 32'h999;
        d_WriteData    = 32'h0;
      end
      WriteDone = (c == 5);
      DataReady = (c == 2);
      #1;
      check("wr_wreq", 32'(WriteRequest), 32'd1);
      check("wr_rreq", 32'(ReadRequest), 32'd0);
      check("wr_addr", Address, 32'h200);
      check("wr_wdata", WriteData, 32'hDEAD_BEEF);
      check("wr_wdone", 32'(d_WriteDone), 32'(c == 5));
      check("wr_drdy", 32'(d_DataReady), 32'd0);
    end
    @(negedge clk);
    WriteDone = 1'b0;
    DataReady = 1'b0;
    #1;
    check("wr_endWreq", 32'(WriteRequest), 32'd0);
    check("wr_endWdone", 32'(d_WriteDone), 32'd0);
    @(negedge clk);
    #1;
    check("wr_idleWreq", 32'(WriteRequest), 32'd0);
    check("wr_idleRreq", 32'(ReadRequest), 32'd0);

    // reset in the middle of a burst
    i_ReadRequest = 1'b1;
    i_ReadAddress = 32'h500;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i_ReadRequest = 1'b0;
      DataReady     = 1'b1;
      DataIn        = 32'hF0 + 32'(k);
      #1;
      check("mid_irdy", 32'(i_DataReady), 32'd1);
    end
    @(negedge clk);
    DataIn = 32'hF2;
    reset  = 1'b0;
    #1;
    check("mid_rreq", 32'(ReadRequest), 32'd0);
    check("mid_addr", Address, 32'd0);
    check("mid_irdy0", 32'(i_DataReady), 32'd0);
    check("mid_idata", i_DataIn, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_irdy", 32'(i_DataReady), 32'd0);
    check("post_drdy", 32'(d_DataReady), 32'd0);
    @(negedge clk);
    #1;
    check("post_rreq", 32'(ReadRequest), 32'd0);
    DataReady     = 1'b0;
    i_ReadRequest = 1'b1;
    i_ReadAddress = 32'h600;
    burst("i037", 1'b1, 32'h600, 32'h10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFails);
    $finish;
  end

endmodule
